// File: rtl/mdu_def.sv
// Shared MDU definitions: op encodings, FSM states and default cycle counts.
`default_nettype none
package mdu_def;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  typedef enum logic [0:0] {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

endpackage
`default_nettype wire

// File: rtl/mdu_arith.sv
// Combinational product / quotient-remainder from the latched operands and op.
`default_nettype none
module mdu_arith
  import mdu_def::*;
(
  input  mdu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div0
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] sa, sb;

  assign sa     = a;
  assign sb     = b;
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign div0   = ((op == MDU_DIV) || (op == MDU_DIVU)) && (b == 32'd0);

  always_comb begin
    hi = 32'd0;
    lo = 32'd0;
    case (op)
      MDU_MULT:  {hi, lo} = prod_s;
      MDU_MULTU: {hi, lo} = prod_u;
      MDU_DIV: begin
        // Most-negative / -1 overflows; pin the architecturally defined result.
        if (b == 32'd0) begin
          hi = 32'd0;
          lo = 32'd0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          hi = 32'd0;
          lo = 32'h8000_0000;
        end else begin
          lo = sa / sb;
          hi = sa % sb;
        end
      end
      MDU_DIVU: begin
        if (b != 32'd0) begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mdu_unit.sv
// Execute-stage multiply/divide unit: FSM, cycle counter, operand latches, HI/LO.
`default_nettype none
module mdu_unit
  import mdu_def::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MDU_op,
  input  logic        md,
  input  logic        mt,
  input  logic        req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        start
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  mdu_state_e  state, state_n;
  logic [CW-1:0] cnt;
  mdu_op_e     op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] res_hi, res_lo;
  logic        div0;
  logic        is_mul, is_md, mt_go, done;

  assign is_mul = (MDU_op == MDU_MULT) || (MDU_op == MDU_MULTU);
  assign is_md  = is_mul || (MDU_op == MDU_DIV) || (MDU_op == MDU_DIVU);
  assign busy   = (state == MDU_RUN);
  assign start  = md && !req && !busy && is_md;
  assign mt_go  = mt && !req && !busy && ((MDU_op == MDU_MTHI) || (MDU_op == MDU_MTLO));
  assign done   = busy && (cnt == CW'(1));

  mdu_arith u_arith (
    .op   (op_q),
    .a    (a_q),
    .b    (b_q),
    .hi   (res_hi),
    .lo   (res_lo),
    .div0 (div0)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= MDU_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      MDU_IDLE: if (start) state_n = MDU_RUN;
      MDU_RUN:  if (done)  state_n = MDU_IDLE;
      default:  state_n = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      op_q <= MDU_NONE;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
      HI   <= 32'd0;
      LO   <= 32'd0;
    end else if (start) begin
      op_q <= mdu_op_e'(MDU_op);
      a_q  <= A;
      b_q  <= B;
      cnt  <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      // Divide by zero still spends the full duration but leaves HI/LO alone.
      if (done && !div0) begin
        HI <= res_hi;
        LO <= res_lo;
      end
    end else if (mt_go) begin
      if (MDU_op == MDU_MTHI) HI <= A;
      else                    LO <= A;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit.
`default_nettype none
module tb_mdu_unit;
  import mdu_def::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  MDU_op;
  logic        md, mt, req;
  logic [31:0] A, B;
  logic [31:0] HI, LO;
  logic        busy, start;

  int n_cmp = 0;
  int n_err = 0;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .MDU_op (MDU_op),
    .md     (md),
    .mt     (mt),
    .req    (req),
    .A      (A),
    .B      (B),
    .HI     (HI),
    .LO     (LO),
    .busy   (busy),
    .start  (start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    md = 1'b0; mt = 1'b0; req = 1'b0; MDU_op = MDU_NONE;
  endtask

  // Issue one md op, disturb inputs while busy, then check duration and result.
  task automatic run_md(input string tag, input mdu_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cnt;
    @(negedge clk);
    md = 1'b1; MDU_op = op; A = a; B = b;
    #1 check({tag, "_start"}, {31'd0, start}, 32'd1);
    @(negedge clk);
    // cycle 1: illegal md while busy, fresh operands on A/B
    md = 1'b1; MDU_op = MDU_MULT; A = ~a; B = 32'd3;
    #1 check({tag, "_nostart"}, {31'd0, start}, 32'd0);
    cnt = 1;
    @(negedge clk);
    // cycle 2: illegal mt while busy
    md = 1'b0; mt = 1'b1; MDU_op = MDU_MTLO; A = 32'hDEAD_BEEF;
    if (busy) cnt++;
    @(negedge clk);
    idle_inputs();
    while (busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check({tag, "_cycles"}, cnt, n);
    check({tag, "_hi"}, HI, exp_hi);
    check({tag, "_lo"}, LO, exp_lo);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    idle_inputs();
    A = 32'd0; B = 32'd0;
    reset = 1'b0;
    #2;
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    run_md("mult",  MDU_MULT,  32'hFFFF_FFFD, 32'd5, 5,  32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_md("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 5,  32'h0000_0001, 32'hFFFF_FFFE);
    run_md("div",   MDU_DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu0", MDU_DIVU,  32'd7,         32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divov", MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    run_md("divu",  MDU_DIVU,  32'd100,       32'd7, 10, 32'd2, 32'd14);

    // mthi suppressed by req
    @(negedge clk);
    mt = 1'b1; req = 1'b1; MDU_op = MDU_MTHI; A = 32'h1234_5678;
    @(negedge clk);
    idle_inputs();
    check("mthi_req", HI, 32'd2);
    @(negedge clk);
    mt = 1'b1; MDU_op = MDU_MTHI; A = 32'h1234_5678;
    @(negedge clk);
    idle_inputs();
    check("mthi", HI, 32'h1234_5678);
    check("mthi_busy", {31'd0, busy}, 32'd0);

    // reserved op and mt with op none: no effect
    @(negedge clk);
    md = 1'b1; MDU_op = MDU_RSVD;
    #1 check("rsvd_start", {31'd0, start}, 32'd0);
    md = 1'b0; mt = 1'b1; MDU_op = MDU_NONE; A = 32'h5555_5555;
    @(negedge clk);
    idle_inputs();
    check("rsvd_hi", HI, 32'h1234_5678);
    check("rsvd_lo", LO, 32'd14);
    check("rsvd_busy", {31'd0, busy}, 32'd0);

    // asynchronous reset mid-cycle
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst_hi", HI, 32'd0);
    check("arst_lo", LO, 32'd14 & 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // div aborted by reset in busy cycle 4
    @(negedge clk);
    md = 1'b1; MDU_op = MDU_DIV; A = 32'd100; B = 32'd7;
    @(negedge clk);
    idle_inputs();
    cnt = 1;
    while (cnt < 4) begin
      @(negedge clk);
      cnt++;
    end
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mt = 1'b1; MDU_op = MDU_MTLO; A = 32'hA5A5_A5A5;
    @(negedge clk);
    idle_inputs();
    check("mtlo", LO, 32'hA5A5_A5A5);
    check("mtlo_hi", HI, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
